// File: rtl/branch_predictor.sv
// -----------------------------------------------------------------------------
// branch_predictor
//
// Dynamic branch predictor next to the FETCH stage. It holds a direct-mapped
// branch target buffer (BTB). Each entry has a valid bit, a tag, a target and
// a saturating confidence counter.
//   - FETCH lookup is combinational on f_pc.
//   - DECODE reports each branch together with its target.
//   - EXEC returns the taken/not-taken outcome FB_LATENCY cycles later. That
//     outcome trains the table.
//
// Optional feature macro: BP_TWO_BIT_CTR_EN
//   defined   : 2-bit saturating counters; a newly allocated entry starts
//               weakly taken (2).
//   undefined : 1-bit last-outcome counter; a newly allocated entry starts
//               at 1.
//
// Ports:
//   clk             in   clock, rising edge
//   rst             in   asynchronous active-high reset
//   f_pc[31:0]      in   PC in FETCH
//   d_pc[31:0]      in   PC in DECODE
//   d_is_branch     in   DECODE holds a conditional branch
//   target_addr     in   branch target from DECODE (valid with d_is_branch)
//   x_predict_res   in   EXEC outcome (1 = taken) for the oldest pending branch
//   f_predict_addr  out  predicted next fetch PC
//   f_predict_valid out  BTB hit with a taken prediction
// -----------------------------------------------------------------------------
module branch_predictor #(
   parameter int IDX_BITS   = 4,
   parameter int FB_LATENCY = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] f_pc,
   input  logic [31:0] d_pc,
   input  logic        d_is_branch,
   input  logic [31:0] target_addr,
   input  logic        x_predict_res,
   output logic [31:0] f_predict_addr,
   output logic        f_predict_valid
);

   localparam int DEPTH = 1 << IDX_BITS;
   localparam int TAG_W = 32 - IDX_BITS - 2;

`ifdef BP_TWO_BIT_CTR_EN
   localparam int CTR_W = 2;
   localparam logic [CTR_W-1:0] CTR_ALLOC = 2'b10;
`else
   localparam int CTR_W = 1;
   localparam logic [CTR_W-1:0] CTR_ALLOC = 1'b1;
`endif

   localparam logic [CTR_W-1:0] CTR_MAX = '1;
   localparam logic [CTR_W-1:0] CTR_ONE = CTR_W'(1);

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [31:0] target;
   } pend_t;

   logic             tbl_valid_q  [DEPTH];
   logic             tbl_valid_d  [DEPTH];
   logic [TAG_W-1:0] tbl_tag_q    [DEPTH];
   logic [TAG_W-1:0] tbl_tag_d    [DEPTH];
   logic [31:0]      tbl_target_q [DEPTH];
   logic [31:0]      tbl_target_d [DEPTH];
   logic [CTR_W-1:0] tbl_ctr_q    [DEPTH];
   logic [CTR_W-1:0] tbl_ctr_d    [DEPTH];

   pend_t pipe_q [FB_LATENCY];
   pend_t pipe_d [FB_LATENCY];

   // Lookup path: it reads only registered table state. An update written
   // on the same edge becomes visible on the following cycle.
   logic [IDX_BITS-1:0] f_idx;
   logic                f_hit;

   assign f_idx = f_pc[IDX_BITS+1:2];
   assign f_hit = tbl_valid_q[f_idx] && (tbl_tag_q[f_idx] == f_pc[31:IDX_BITS+2]);

   // The MSB of the counter is the taken prediction in both counter widths.
   assign f_predict_valid = f_hit && tbl_ctr_q[f_idx][CTR_W-1];
   assign f_predict_addr  = f_predict_valid ? tbl_target_q[f_idx] : (f_pc + 32'd4);

   // Resolution path: the oldest pipe stage pairs with this cycle's x_predict_res.
   pend_t               res;
   logic [IDX_BITS-1:0] res_idx;
   logic                res_hit;
   logic [CTR_W-1:0]    res_ctr;
   logic                unused_pc_lsbs;

   assign res            = pipe_q[FB_LATENCY-1];
   assign res_idx        = res.pc[IDX_BITS+1:2];
   assign res_hit        = tbl_valid_q[res_idx] && (tbl_tag_q[res_idx] == res.pc[31:IDX_BITS+2]);
   assign res_ctr        = tbl_ctr_q[res_idx];
   assign unused_pc_lsbs = ^res.pc[1:0];

   always_comb begin
      tbl_valid_d  = tbl_valid_q;
      tbl_tag_d    = tbl_tag_q;
      tbl_target_d = tbl_target_q;
      tbl_ctr_d    = tbl_ctr_q;

      pipe_d[0] = '{valid: d_is_branch, pc: d_pc, target: target_addr};
      for (int i = 1; i < FB_LATENCY; i++) begin
         pipe_d[i] = pipe_q[i-1];
      end

      // At most one entry (res_idx) is written per cycle.
      if (res.valid) begin
         if (x_predict_res) begin
            if (res_hit) begin
               tbl_ctr_d[res_idx]    = (res_ctr == CTR_MAX) ? CTR_MAX : (res_ctr + CTR_ONE);
               tbl_target_d[res_idx] = res.target;
            end else begin
               tbl_valid_d[res_idx]  = 1'b1;
               tbl_tag_d[res_idx]    = res.pc[31:IDX_BITS+2];
               tbl_target_d[res_idx] = res.target;
               tbl_ctr_d[res_idx]    = CTR_ALLOC;
            end
         end else if (res_hit) begin
            tbl_ctr_d[res_idx] = (res_ctr == '0) ? '0 : (res_ctr - CTR_ONE);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tbl_valid_q  <= '{default: 1'b0};
         tbl_tag_q    <= '{default: '0};
         tbl_target_q <= '{default: '0};
         tbl_ctr_q    <= '{default: '0};
         pipe_q       <= '{default: '0};
      end else begin
         tbl_valid_q  <= tbl_valid_d;
         tbl_tag_q    <= tbl_tag_d;
         tbl_target_q <= tbl_target_d;
         tbl_ctr_q    <= tbl_ctr_d;
         pipe_q       <= pipe_d;
      end
   end

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;

   localparam int IDX_BITS = 4;
   localparam int FB_LAT   = 2;
   localparam int DEPTH    = 16;

`ifdef BP_TWO_BIT_CTR_EN
   localparam int M_MAX   = 3;
   localparam int M_ALLOC = 2;
   localparam int M_THR   = 2;
`else
   localparam int M_MAX   = 1;
   localparam int M_ALLOC = 1;
   localparam int M_THR   = 1;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] f_pc = '0;
   logic [31:0] d_pc = '0;
   logic        d_is_branch = 1'b0;
   logic [31:0] target_addr = '0;
   logic        x_predict_res = 1'b0;
   logic [31:0] f_predict_addr;
   logic        f_predict_valid;

   branch_predictor #(.IDX_BITS(IDX_BITS), .FB_LATENCY(FB_LAT)) dut (
      .clk(clk), .rst(rst), .f_pc(f_pc), .d_pc(d_pc), .d_is_branch(d_is_branch),
      .target_addr(target_addr), .x_predict_res(x_predict_res),
      .f_predict_addr(f_predict_addr), .f_predict_valid(f_predict_valid));

   always #5 clk = ~clk;

   typedef struct {
      bit          valid;
      logic [31:0] addr;
      logic [31:0] pc;
   } exp_t;

   typedef struct {
      bit          valid;
      logic [31:0] pc;
      logic [31:0] tgt;
   } rep_t;

   // Reference model: the table as plain arrays, and the outstanding
   // reports as a queue of in-flight branches.
   bit          m_valid [DEPTH];
   int unsigned m_tag   [DEPTH];
   logic [31:0] m_tgt   [DEPTH];
   int          m_ctr   [DEPTH];
   rep_t        pend    [$];
   exp_t        exp_q   [$];

   int n_checks = 0;
   int n_fail   = 0;
   bit done     = 0;

   function automatic int idx_of(input logic [31:0] pc);
      return int'((pc / 4) % DEPTH);
   endfunction

   function automatic int unsigned tag_of(input logic [31:0] pc);
      return pc / (4 * DEPTH);
   endfunction

   function automatic bit m_hit(input logic [31:0] pc);
      int i = idx_of(pc);
      return m_valid[i] && (m_tag[i] == tag_of(pc));
   endfunction

   task automatic model_reset();
      for (int i = 0; i < DEPTH; i++) begin
         m_valid[i] = 0;
         m_ctr[i]   = 0;
         m_tag[i]   = 0;
         m_tgt[i]   = '0;
      end
      pend.delete();
   endtask

   function automatic exp_t model_lookup(input logic [31:0] pc);
      exp_t e;
      int   i = idx_of(pc);
      e.pc = pc;
      e.valid = m_hit(pc) && (m_ctr[i] >= M_THR);
      e.addr  = e.valid ? m_tgt[i] : pc + 32'd4;
      return e;
   endfunction

   task automatic model_clock(input bit br, input logic [31:0] dpc,
                              input logic [31:0] tgt, input bit xr);
      rep_t r;
      if (pend.size() == FB_LAT) begin
         r = pend.pop_front();
         if (r.valid) begin
            int i = idx_of(r.pc);
            if (xr) begin
               if (m_hit(r.pc)) begin
                  if (m_ctr[i] < M_MAX) m_ctr[i] = m_ctr[i] + 1;
                  m_tgt[i] = r.tgt;
               end else begin
                  m_valid[i] = 1;
                  m_tag[i]   = tag_of(r.pc);
                  m_tgt[i]   = r.tgt;
                  m_ctr[i]   = M_ALLOC;
               end
            end else if (m_hit(r.pc)) begin
               if (m_ctr[i] > 0) m_ctr[i] = m_ctr[i] - 1;
            end
         end
      end
      r.valid = br;
      r.pc    = dpc;
      r.tgt   = tgt;
      pend.push_back(r);
   endtask

   // One cycle: drive at the falling edge, queue the expected lookup result,
   // then advance the model at the rising edge.
   task automatic step(input logic [31:0] fpc, input bit br, input logic [31:0] dpc,
                       input logic [31:0] tgt, input bit xr, input bit do_rst);
      @(negedge clk);
      f_pc          = fpc;
      d_is_branch   = br;
      d_pc          = dpc;
      target_addr   = tgt;
      x_predict_res = xr;
      rst           = do_rst;
      if (do_rst) model_reset();
      exp_q.push_back(model_lookup(fpc));
      @(posedge clk);
      if (!do_rst) model_clock(br, dpc, tgt, xr);
   endtask

   task automatic idle(input logic [31:0] fpc, input bit xr);
      step(fpc, 0, 32'h0000_2000 + 4 * $urandom_range(0, 15), $urandom, xr, 0);
   endtask

   // Report a branch, then supply its outcome in the resolving slot.
   task automatic resolve(input logic [31:0] pc, input logic [31:0] tgt, input bit taken);
      step(32'h0000_3000, 1, pc, tgt, $urandom_range(0, 1), 0);
      idle(32'h0000_3000, $urandom_range(0, 1));
      idle(32'h0000_3000, taken);
   endtask

   function automatic logic [31:0] rand_pc();
      if ($urandom_range(0, 49) == 0) return 32'hFFFF_FFFC;
      return 32'h0000_1000 + 4 * $urandom_range(0, 23);
   endfunction

   // Monitor: compares each queued expectation with the DUT outputs.
   initial begin
      exp_t e;
      while (!done) begin
         @(negedge clk);
         #2;
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (f_predict_valid !== e.valid) begin
               n_fail++;
               $display("FAIL valid pc=%h: got %b expected %b", e.pc, f_predict_valid, e.valid);
            end
            n_checks++;
            if (f_predict_addr !== e.addr) begin
               n_fail++;
               $display("FAIL addr pc=%h: got %h expected %h", e.pc, f_predict_addr, e.addr);
            end
         end
      end
   end

   initial begin
      model_reset();
      step(32'h0000_1000, 0, 0, 0, 0, 1);
      step(32'h0000_1000, 0, 0, 0, 0, 0);

      // Taken branch allocates; the next lookup predicts the target.
      resolve(32'h0000_1014, 32'h0000_1000, 1);
      idle(32'h0000_1014, 0);
      // A not-taken first report does not allocate.
      resolve(32'h0000_1008, 32'h0000_1010, 0);
      idle(32'h0000_1008, 1);
      // Counter behaviour: one not-taken, three taken, then one not-taken.
      resolve(32'h0000_1014, 32'h0000_1000, 0);
      idle(32'h0000_1014, 0);
      for (int k = 0; k < 3; k++) resolve(32'h0000_1014, 32'h0000_1000, 1);
      idle(32'h0000_1014, 0);
      resolve(32'h0000_1014, 32'h0000_1000, 0);
      idle(32'h0000_1014, 0);
      // Same-cycle lookup and update to one index: the lookup sees the old state.
      step(32'h0000_1030, 1, 32'h0000_1030, 32'h0000_1100, 0, 0);
      idle(32'h0000_1030, 0);
      idle(32'h0000_1030, 1);
      idle(32'h0000_1030, 0);

      // A reset drops the pending branch, so its feedback is discarded.
      step(32'h0000_1014, 1, 32'h0000_1014, 32'h0000_1000, 0, 0);
      step(32'h0000_1014, 0, 0, 0, 1, 1);
      idle(32'h0000_1014, 1);
      idle(32'h0000_1014, 1);
      idle(32'h0000_1014, 0);

      // Two PCs alias to one index: only the later allocation hits.
      resolve(32'h0000_1004, 32'h0000_1200, 1);
      resolve(32'h0000_1044, 32'h0000_1300, 1);
      idle(32'h0000_1004, 0);
      idle(32'h0000_1044, 0);
      idle(32'hFFFF_FFFC, 0);

      // Random traffic, biased toward taken outcomes, with rare resets.
      for (int n = 0; n < 3000; n++) begin
         step(rand_pc(), $urandom_range(0, 3) != 0, rand_pc(), $urandom,
              $urandom_range(0, 9) < 7, $urandom_range(0, 299) == 0);
      end

      for (int w = 0; w < 4 && exp_q.size() != 0; w++) @(negedge clk);
      #3;
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      end
      done = 1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
